// File: rtl/alu_ctrl_seq.sv
// Multi-cycle RV32I subset control sequencer (FETCH/DECODE/EXEC/WB/HALT) for the ALU/register-file datapath.
// Optional retired-instruction counter is enabled by defining ALU_CTRL_SEQ_INSTRET_EN.
module alu_ctrl_seq #(
    parameter int                    ADDRESS_WIDTH = 5,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic                     EQ,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic                     RegWrite,
    output logic                     ALUsrc,
    output logic [2:0]               ALUctrl,
    output logic [DATA_WIDTH-1:0]    immOp,
    output logic [DATA_WIDTH-1:0]    pc,
    output logic                     illegal,
    output logic [31:0]              instret
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] CTRL_ADD = 3'b000;
    localparam logic [2:0] CTRL_SUB = 3'b001;
    localparam logic [2:0] CTRL_CMP = 3'b010;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   instr_q;
    logic                    is_write;
    logic                    is_branch;
    logic                    is_bne;
    logic                    eq_q;

    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic [6:0]              funct7;
    logic [DATA_WIDTH-1:0]   imm_i;
    logic [DATA_WIDTH-1:0]   imm_b;

    logic                    dec_legal;
    logic                    dec_src;
    logic [2:0]              dec_ctrl;
    logic [DATA_WIDTH-1:0]   dec_imm;
    logic                    dec_write;
    logic                    dec_branch;
    logic                    dec_bne;
    logic                    taken;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];
    assign imm_i  = {{(DATA_WIDTH-12){instr_q[31]}}, instr_q[31:20]};
    assign imm_b  = {{(DATA_WIDTH-13){instr_q[31]}}, instr_q[31], instr_q[7],
                     instr_q[30:25], instr_q[11:8], 1'b0};

    always_comb begin
        dec_legal  = 1'b0;
        dec_src    = 1'b0;
        dec_ctrl   = CTRL_ADD;
        dec_imm    = '0;
        dec_write  = 1'b0;
        dec_branch = 1'b0;
        dec_bne    = 1'b0;
        case (opcode)
            OP_IMM: begin
                if (funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_src   = 1'b1;
                    dec_imm   = imm_i;
                    dec_write = 1'b1;
                end
            end
            OP_REG: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    dec_write = 1'b1;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = CTRL_SUB;
                    dec_write = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    dec_legal  = 1'b1;
                    dec_ctrl   = CTRL_CMP;
                    dec_imm    = imm_b;
                    dec_branch = 1'b1;
                    dec_bne    = funct3[0];
                end
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // EQ is captured at the end of EXEC, so the branch decision in WB uses that sample.
    assign taken = is_branch && (is_bne ? !eq_q : eq_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            instr_q     <= '0;
            instr_ready <= 1'b0;
            pc          <= RESET_PC;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            immOp       <= '0;
            ALUctrl     <= '0;
            ALUsrc      <= 1'b0;
            RegWrite    <= 1'b0;
            illegal     <= 1'b0;
            is_write    <= 1'b0;
            is_branch   <= 1'b0;
            is_bne      <= 1'b0;
            eq_q        <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (instr_valid && instr_ready) begin
                        instr_q     <= instr;
                        instr_ready <= 1'b0;
                        state       <= S_DECODE;
                    end else begin
                        instr_ready <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        rs1       <= ADDRESS_WIDTH'(instr_q[19:15]);
                        rs2       <= ADDRESS_WIDTH'(instr_q[24:20]);
                        rd        <= ADDRESS_WIDTH'(instr_q[11:7]);
                        immOp     <= dec_imm;
                        ALUsrc    <= dec_src;
                        ALUctrl   <= dec_ctrl;
                        is_write  <= dec_write;
                        is_branch <= dec_branch;
                        is_bne    <= dec_bne;
                        state     <= S_EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state   <= S_HALT;
                    end
                end
                S_EXEC: begin
                    eq_q     <= EQ;
                    RegWrite <= is_write && (rd != '0);
                    state    <= S_WB;
                end
                S_WB: begin
                    RegWrite    <= 1'b0;
                    instr_ready <= 1'b1;
                    pc          <= taken ? pc + immOp : pc + DATA_WIDTH'(4);
                    state       <= S_FETCH;
                end
                S_HALT: begin
                    RegWrite    <= 1'b0;
                    instr_ready <= 1'b0;
                end
                default: begin
                    RegWrite    <= 1'b0;
                    instr_ready <= 1'b0;
                    state       <= S_FETCH;
                end
            endcase
        end
    end

`ifdef ALU_CTRL_SEQ_INSTRET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (state == S_WB) begin
            instret <= instret + 32'd1;
        end
    end
`else
    assign instret = '0;
`endif

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Multi-cycle control sequencer that drives the ALU/register-file datapath: register addresses, ALU source select, ALU operation, sign-extended immediate and register write enable.
- Accepts one 32-bit RV32I instruction per valid/ready handshake, decodes a fixed subset and sequences it through DECODE/EXEC/WB.
- Samples the datapath EQ flag to resolve branches and maintains the PC.
- Sits between instruction fetch and the ALU/register-file top.

Parameters:
- ADDRESS_WIDTH, 5, register address width.
- DATA_WIDTH, 32, instruction/immediate/PC width.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr  input  DATA_WIDTH  instruction word; valid only with instr_valid.
- instr_valid  input  1  fetch side offers instr.
- instr_ready  output  1  sequencer accepts instr.
- EQ  input  1  ALU equality flag (ALUop1 == ALUop2).
- rs1, rs2, rd  output  ADDRESS_WIDTH each  register addresses.
- RegWrite  output  1  register file write enable.
- ALUsrc  output  1  0 = register operand 2, 1 = immOp.
- ALUctrl  output  3  000 add, 001 sub, 010 compare.
- immOp  output  DATA_WIDTH  sign-extended immediate.
- pc  output  DATA_WIDTH  current program counter.
- illegal  output  1  sticky unsupported-instruction flag.
- instret  output  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset values (async on rst_n low):
  - State FETCH; pc = RESET_PC.
  - rs1, rs2, rd, immOp, ALUctrl, ALUsrc, RegWrite, illegal, instret all 0.
  - instr_ready = 0 while rst_n is low, and 1 from the first clock after release.
- FETCH:
  - instr_ready = 1.
  - On instr_valid && instr_ready: latch instr and go to DECODE. Otherwise hold.
- DECODE (1 cycle), instr_ready = 0. Decode and register fields:
  - ADDI (opcode 0010011, f3 000): ALUsrc=1, ALUctrl=000, imm = sext(instr[31:20]).
  - ADD (0110011, f3 000, f7 0000000): ALUsrc=0, ALUctrl=000.
  - SUB (0110011, f3 000, f7 0100000): ALUsrc=0, ALUctrl=001.
  - BEQ/BNE (1100011, f3 000/001): ALUsrc=0, ALUctrl=010, imm = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - Any other encoding: set illegal and go to HALT.
- EXEC (1 cycle): outputs held stable; EQ is sampled at the end of the cycle.
- WB (1 cycle):
  - RegWrite = 1 only for ADDI/ADD/SUB with rd != 0. Never for branches or rd = x0.
  - pc updates at the end of WB:
    - taken branch (BEQ && EQ, or BNE && !EQ): pc <= pc + immOp.
    - otherwise: pc <= pc + 4.
  - Next state is FETCH.
- HALT: instr_ready = 0, RegWrite = 0, pc frozen. Only reset exits.
- Latency: 4 cycles per instruction from handshake to the next instr_ready, i.e. throughput of 1 instruction per 4 cycles.
- Arithmetic: PC addition is modulo 2^DATA_WIDTH (wraps silently); branch offset is two's complement.
- rs1/rs2/rd/immOp/ALUsrc/ALUctrl keep their last decoded values in FETCH and HALT.
- RegWrite is 0 in every state except WB.
- Reset asserted mid-instruction aborts it immediately: no write, pc = RESET_PC.
- instr_valid dropping before handshake is legal; no state change.

Optional Feature:
- Macro ALU_CTRL_SEQ_INSTRET_EN.
- Defined: instret increments by 1 (wrapping at 2^32) at the end of every WB cycle, i.e. once per retired instruction including branches. Reset value 0.
- Undefined: instret is constant 0 and no counter flops exist.

Test Plan:
- Reset release, then ADDI x5,x0,-3 (0xFFD00293) -> DECODE: rd=5, rs1=0, immOp=0xFFFFFFFD, ALUsrc=1, ALUctrl=000; RegWrite=1 for exactly the WB cycle; pc 0 -> 4; instr_ready back 4 cycles after the handshake.
- SUB x3,x1,x2 (0x402081B3) -> ALUsrc=0, ALUctrl=001, rs1=1, rs2=2, rd=3, single-cycle RegWrite; ADDI x0,x0,1 (0x00100013) -> RegWrite stays 0.
- BNE x1,x2,-8 (0xFE209CE3) at pc=0x10 with EQ=0 -> pc=0x08, RegWrite 0; same instruction with EQ=1 -> pc=0x14.
- Illegal 0x00000000 -> illegal=1, instr_ready stays 0 for 20 cycles, pc frozen; assert rst_n=0 -> illegal=0, pc=RESET_PC.
- rst_n pulled low during EXEC of ADD -> no RegWrite pulse, state FETCH, pc=RESET_PC. Separately, BEQ with offset +8 at pc=0xFFFFFFFC and EQ=1 -> pc wraps to 0x00000004.
- With ALU_CTRL_SEQ_INSTRET_EN defined, retire 3 instructions (ADDI, BNE, ADD) -> instret=3; without the macro -> instret=0 throughout.
